// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory bus: request, status report and responder observation signals.
// Latency: none (wires only); the responder registers its read data one edge after the request.
// Backpressure: none; the responder accepts one access per cycle unconditionally.
//
// Ports (signals):
//   i_wen, i_addr, i_wdata      - data-port request from the core
//   i_status, i_status_valid    - retired-instruction status report
//   o_rdata                     - registered read data
//   o_err, o_state              - sticky access error, controller state
//   o_inst_cnt, o_wr_cnt        - saturating instruction / write counters
interface data_mem_responder_if #(
    parameter int AW = 32
);
    logic          i_wen;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_wdata;
    logic [1:0]    i_status;
    logic          i_status_valid;
    logic [31:0]   o_rdata;
    logic          o_err;
    logic [1:0]    o_state;
    logic [15:0]   o_inst_cnt;
    logic [15:0]   o_wr_cnt;

    // Core side drives requests and observes the responder.
    modport master (
        output i_wen, i_addr, i_wdata, i_status, i_status_valid,
        input  o_rdata, o_err, o_state, o_inst_cnt, o_wr_cnt
    );

    // Responder side consumes requests and drives the observation outputs.
    modport slave (
        input  i_wen, i_addr, i_wdata, i_status, i_status_valid,
        output o_rdata, o_err, o_state, o_inst_cnt, o_wr_cnt
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for a core's data port, with run/halt/fault controller and counters.
// Latency: read data registered, one edge after the address; writes land on the request edge.
// Backpressure: none; every cycle is accepted, writes are dropped outside RUN or when illegal.
//
// Ports:
//   i_clk    - single clock, all state changes on the rising edge
//   i_rst_n  - asynchronous active-low reset; clears memory, counters, flags and state
//   bus      - slave modport of data_mem_responder_if (request, status, observation outputs)
module data_mem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    data_mem_responder_if.slave   bus
);

    localparam int IW = $clog2(DEPTH);

    // Status codes reported by the core.
    localparam logic [1:0] ST_R_SUCCESS = 2'd0;
    localparam logic [1:0] ST_I_SUCCESS = 2'd1;
    localparam logic [1:0] ST_OVERFLOW  = 2'd2;
    localparam logic [1:0] ST_END       = 2'd3;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;
    state_t      r_state;
    logic [15:0] r_inst_cnt;
    logic [15:0] r_wr_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IW-1:0] w_index;
    logic          w_aligned;
    logic          w_in_range;
    logic          w_legal;

    assign w_index   = bus.i_addr[IW+1:2];
    assign w_aligned = (bus.i_addr[1:0] == 2'b00);
    // Any address bit at or above 4*DEPTH makes the access out of range;
    // this also stops high addresses aliasing onto low words.
    assign w_in_range = ((bus.i_addr >> (IW + 2)) == '0);
    assign w_legal    = w_aligned && w_in_range;

    // ------------------------------------------------------------------
    // Controller: next state and per-cycle actions
    // ------------------------------------------------------------------
    state_t w_state_nxt;
    logic   w_wr_commit;
    logic   w_wr_illegal;
    logic   w_inst_inc;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_commit  = 1'b0;
        w_wr_illegal = 1'b0;
        w_inst_inc   = 1'b0;

        // An illegal write flags an error in any state; it never touches memory.
        if (bus.i_wen && !w_legal) begin
            w_wr_illegal = 1'b1;
        end

        unique case (r_state)
            S_RUN: begin
                // Write is judged against the current (pre-edge) state, so a
                // write coinciding with END/OVERFLOW still commits.
                if (bus.i_wen && w_legal) begin
                    w_wr_commit = 1'b1;
                end
                if (bus.i_status_valid) begin
                    case (bus.i_status)
                        ST_R_SUCCESS,
                        ST_I_SUCCESS: w_inst_inc  = 1'b1;
                        ST_OVERFLOW:  w_state_nxt = S_FAULT;
                        ST_END:       w_state_nxt = S_HALTED;
                        default:      w_state_nxt = r_state;
                    endcase
                end
            end
            // Terminal until reset: writes dropped, status ignored.
            S_HALTED: w_state_nxt = S_HALTED;
            S_FAULT:  w_state_nxt = S_FAULT;
            default:  w_state_nxt = S_FAULT;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory array: cleared by reset, one write port
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_wr_commit) begin
            r_mem[w_index] <= bus.i_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port: samples the array before this edge's write lands, so a
    // same-address write and read returns the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'h0;
        end else if (w_legal) begin
            r_rdata <= r_mem[w_index];
        end else begin
            r_rdata <= 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_wr_illegal) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst_cnt <= 16'h0;
        end else if (w_inst_inc && (r_inst_cnt != 16'hFFFF)) begin
            r_inst_cnt <= r_inst_cnt + 16'h1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt <= 16'h0;
        end else if (w_wr_commit && (r_wr_cnt != 16'hFFFF)) begin
            r_wr_cnt <= r_wr_cnt + 16'h1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_rdata    = r_rdata;
    assign bus.o_err      = r_err;
    assign bus.o_state    = r_state;
    assign bus.o_inst_cnt = r_inst_cnt;
    assign bus.o_wr_cnt   = r_wr_cnt;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter: AW, 32, width of byte address input.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_wen  input  1  write enable from core data port.
REQ-006 i_addr  input  AW  byte address from core.
REQ-007 i_wdata  input  32  write data.
REQ-008 o_rdata  output  32  registered read data.
REQ-009 i_status  input  2  core status code: 0 R_TYPE_SUCCESS, 1 I_TYPE_SUCCESS, 2 MIPS_OVERFLOW, 3 MIPS_END.
REQ-010 i_status_valid  input  1  i_status qualifier, one cycle per retired instruction.
REQ-011 o_err  output  1  sticky access-error flag.
REQ-012 o_state  output  2  FSM state: 0 RUN, 1 HALTED, 2 FAULT.
REQ-013 o_inst_cnt  output  16  count of valid success statuses.
REQ-014 o_wr_cnt  output  16  count of committed writes.

Function
REQ-015 Word index = i_addr[log2(DEPTH)+1:2]; access legal only if i_addr[1:0]==0 and i_addr < 4*DEPTH.
REQ-016 Read: every rising edge, o_rdata <= mem[index] if legal, else 32'h0; latency exactly one cycle, independent of i_wen.
REQ-017 Same-cycle write and read of one address: o_rdata returns the pre-write (old) word; new word visible on the following edge.
REQ-018 Write commits only when i_wen=1, access legal, and state==RUN; a committed write increments o_wr_cnt.
REQ-019 i_wen=1 with illegal access sets o_err (sticky until reset); memory unchanged; o_wr_cnt unchanged.
REQ-020 Read of illegal address while i_wen=0 does not set o_err.
REQ-021 FSM RUN -> HALTED on i_status_valid with i_status==3.
REQ-022 FSM RUN -> FAULT on i_status_valid with i_status==2.
REQ-023 HALTED and FAULT are terminal until reset; writes ignored; reads continue normally.
REQ-024 In RUN, i_status_valid with status 0 or 1 increments o_inst_cnt; no increment in other states or for codes 2/3.
REQ-025 Counters saturate at 16'hFFFF; no wrap.
REQ-026 Write and status transition on the same edge: the write is evaluated against the pre-edge state (RUN -> write commits).
REQ-027 i_status_valid=0: i_status ignored entirely.

Reset
REQ-028 On i_rst_n=0, asynchronously: all mem words = 0, o_rdata = 0, o_err = 0, o_state = RUN, o_inst_cnt = 0, o_wr_cnt = 0.
REQ-029 Reset asserted mid-operation discards all contents and counters; first post-reset edge behaves as from power-up.
REQ-030 Outputs hold reset values while i_rst_n=0 regardless of i_clk.

Verification
REQ-031 Write 32'hDEADBEEF to addr 0x10, next cycle read 0x10 -> o_rdata=32'hDEADBEEF one edge later; o_wr_cnt=1.
REQ-032 Write addr 0x13 (misaligned) and addr 4*DEPTH -> o_err=1, o_wr_cnt=0, read of 0x10 returns prior value.
REQ-033 Write 0x20=32'h1 then same-cycle write 0x20=32'h2 with read 0x20 -> o_rdata=32'h1, next edge 32'h2.
REQ-034 Three valid status 0/1/0 then status 3 -> o_inst_cnt=3, o_state=HALTED; later write 0x8 ignored, read 0x8 returns 0.
REQ-035 Status 2 in same cycle as write 0x4=32'hA5 -> write commits, o_state=FAULT, o_inst_cnt unchanged.
REQ-036 Assert i_rst_n=0 mid-cycle after writes -> immediate zero outputs, o_state=RUN, read 0x10 returns 0 after release.
